baud_gen_frac: RTL

Programmable fractional baud-rate generator. It divides `clk_50m` into a pair of single-cycle enables: an oversampling receive enable and a transmit enable at 1/OVERSAMPLE of that rate. The divisor has an integer and a fractional part and can be reloaded at run time, so one instance serves any baud rate without resynthesis. It sits between the system clock and the UART rx/tx engines, replacing the fixed-115200 generator.

---
 rtl/baud_gen_frac.sv | 94 +++++++++
 1 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: an oversampled rx tick plus a tx tick every OVERSAMPLE rx ticks,
// both derived from clk_50m through an integer.fraction divisor that can be reloaded while running.
module baud_gen_frac #(
    parameter int INT_W          = 16,
    parameter int FRAC_W         = 4,
    parameter int OVERSAMPLE     = 16,
    parameter int RESET_DIV_INT  = 27,
    parameter int RESET_DIV_FRAC = 4
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              rxclk_en,
    output logic              txclk_en,
    output logic              cfg_err
);
    localparam int              OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [INT_W-1:0]  act_int, pend_int, cnt, term;
    logic [FRAC_W-1:0] act_frac, pend_frac, facc;
    logic [FRAC_W:0]   facc_sum;
    logic [OS_W-1:0]   os_cnt;
    logic              pend_v, extra, wrap, load_ok, apply;

    // A stretched period ends one count later; extra only ever adds 0 or 1.
    assign term     = act_int - INT_W'(1) + INT_W'(extra);
    assign wrap     = enable && (cnt == term);
    assign facc_sum = {1'b0, facc} + {1'b0, act_frac};
    assign load_ok  = div_load && (div_int >= INT_W'(2));
    // Staged divisor only lands on a period boundary (or while idle).
    assign apply    = pend_v && (wrap || !enable);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            act_int   <= INT_W'(RESET_DIV_INT);
            act_frac  <= FRAC_W'(RESET_DIV_FRAC);
            pend_int  <= '0;
            pend_frac <= '0;
            pend_v    <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            if (apply) begin
                act_int  <= pend_int;
                act_frac <= pend_frac;
            end
            if (load_ok) begin
                pend_int  <= div_int;
                pend_frac <= div_frac;
            end
            if (div_load)
                cfg_err <= !load_ok;
            // A load coinciding with an apply re-arms pending with the new value.
            if (load_ok)
                pend_v <= 1'b1;
            else if (apply)
                pend_v <= 1'b0;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            facc   <= '0;
            extra  <= 1'b0;
            os_cnt <= '0;
        end else if (!enable) begin
            cnt    <= '0;
            facc   <= '0;
            extra  <= 1'b0;
            os_cnt <= '0;
        end else if (wrap) begin
            cnt    <= '0;
            facc   <= facc_sum[FRAC_W-1:0];
            extra  <= facc_sum[FRAC_W];
            os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
        end else begin
            cnt <= cnt + INT_W'(1);
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rxclk_en <= 1'b0;
            txclk_en <= 1'b0;
        end else begin
            rxclk_en <= wrap;
            txclk_en <= wrap && (os_cnt == OS_LAST);
        end
    end
endmodule
